boot_loader_ctrl: RTL
=====================

# boot_loader_ctrl

UART boot-loader sequencer placed between the UART RX FIFO and instruction memory. It parses a framed image (sync byte, 32-bit length, payload, checksum) from the FIFO and writes payload bytes to memory from address 0. It holds the CPU in reset while loading and releases it only after a verified image. Bad frames are reported through an error code.

## Interface
- MEM_SIZE, 32768: memory capacity in bytes; maximum legal image length.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYC, 1000000: maximum clk cycles allowed between consumed bytes inside a frame.
- clk  input  1  single clock for all state.
- rstB  input  1  asynchronous, active-low reset.
- bootReq  input  1  load request level (pin/button), already synchronized upstream.
- rxFfEmpty  input  1  RX FIFO empty flag (1 = empty).
- rxRdEn  output  1  FIFO read strobe; read latency is 1 cycle.
- rxData  input  8  FIFO read data, valid the cycle after rxRdEn.
- memWrEn  output  1  byte write strobe.
- memAddr  output  32  byte address.
- memData  output  8  write data.
- cpuRstB  output  1  CPU reset, active-low.
- busy  output  1  high in SYNC/LEN/DATA/CSUM.
- done  output  1  one-cycle pulse on a verified load.
- err  output  2  sticky error code: 00 none, 01 bad length, 10 checksum mismatch, 11 timeout.

## Operation
- States: BOOT, SYNC, LEN, DATA, CSUM, DONE, ERR, RUN.
- Reset values:
  - Outputs: state BOOT, cpuRstB=0, rxRdEn=0, memWrEn=0, memAddr=0, memData=0, done=0, err=00, busy=0.
  - Internal: len=0, cnt=0, sum=0, timer=0, rdPend=0.
- BOOT is a one-cycle decision state:
  - bootReq=1 -> SYNC.
  - bootReq=0 -> RUN.
- RUN: cpuRstB=1. A rising edge of bootReq (registered previous value) -> SYNC with cpuRstB=0 in the same cycle. bootReq changes in any other state are ignored.
- Byte fetch, active in SYNC/LEN/DATA/CSUM:
  - rxRdEn = !rxFfEmpty & !rdPend.
  - rdPend <= rxRdEn.
  - A byte is "consumed" in the cycle rdPend=1, using rxData.
  - Maximum rate is one byte per 2 cycles.
- SYNC:
  - Consumed byte == SYNC_BYTE -> LEN; clear err, len, cnt, sum.
  - Any other byte is discarded.
  - No timeout in this state.
- LEN:
  - Four bytes, little-endian, assembled into len[31:0].
  - After the 4th byte: len==0 or len>MEM_SIZE (unsigned 32-bit compare) -> ERR with err=01; otherwise -> DATA.
- DATA, for each consumed byte:
  - memWrEn=1 for that cycle, memData=rxData, memAddr=cnt.
  - Then cnt<=cnt+1 and sum<=sum+rxData (8-bit, wraps mod 256).
  - When cnt+1==len -> CSUM.
- CSUM: one consumed byte.
  - Equals sum -> DONE.
  - Otherwise -> ERR with err=10.
- DONE: done=1 for one cycle, then RUN (cpuRstB=1).
- ERR: one cycle, then SYNC. err holds its code until the next SYNC_BYTE is accepted. cpuRstB stays 0.
- Timeout (LEN/DATA/CSUM only):
  - timer resets on every consumed byte and on state entry, and increments otherwise.
  - timer==TIMEOUT_CYC-1 -> ERR with err=11.
  - If a byte is consumed in the same cycle, the byte wins and no timeout is taken.
- memWrEn is never asserted outside DATA. memAddr never reaches MEM_SIZE.
- Reset asserted mid-frame returns everything to reset values immediately; a partially written image is not erased.

## Timing
- rxRdEn at cycle N -> byte consumed (and for payload, memWrEn) at N+1.
- Last payload write at cycle T -> CSUM state at T+1. Earliest checksum read is at T+1; it is consumed at T+2.
- Checksum consumed at cycle C:
  - Match: done=1 at C+1; cpuRstB rises at C+2 (RUN).
  - Mismatch: ERR at C+1 with err=10 visible; SYNC at C+2.
- Minimum load time for length L with a never-empty FIFO: 2*(1+4+L+1) cycles from SYNC entry to DONE.
- busy is registered from state and asserts the cycle after SYNC entry.
- Registered bootReq edge in RUN: cpuRstB=0 in the following cycle.

## Test plan
- Boot path: reset with bootReq=0 -> RUN, cpuRstB=1 two cycles after rstB deasserts; memWrEn never asserted.
- Good load: bootReq=1. Send garbage 0x00 0x5A, then A5, 04 00 00 00, 11 22 33 44, checksum AA.
  - Required: writes addr0..3 = 11,22,33,44; done pulse; cpuRstB=1; err=00.
- Bad checksum: same frame with checksum AB.
  - Required: 4 writes, err=10, cpuRstB stays 0, state returns to SYNC.
  - A following good frame clears err to 00 on its sync byte.
- Length checks:
  - len=0 -> err=01, no writes.
  - len=MEM_SIZE+1 -> err=01.
  - len=MEM_SIZE -> last write at memAddr=MEM_SIZE-1, done pulse.
- Timeout: stall the FIFO empty after 2 payload bytes with TIMEOUT_CYC=16.
  - Required: err=11 exactly 16 cycles after the last consumed byte.
  - Byte arriving on the terminal cycle: no error taken.
- Re-boot and reset mid-load:
  - bootReq rising edge in RUN -> cpuRstB=0 and SYNC.
  - rstB pulsed low during DATA -> all outputs at reset values immediately; next frame loads correctly.

Source files
------------

// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl
// UART boot-loader sequencer between the UART RX FIFO and instruction memory.
// Parses a frame (SYNC_BYTE, 32-bit little-endian length, payload, 8-bit
// additive checksum), writes payload bytes to memory from address 0, holds
// the CPU in reset while loading and releases it only after a verified image.
//
// Ports:
//   clk        single clock
//   rstB       asynchronous active-low reset
//   bootReq    load request level (already synchronized)
//   rxFfEmpty  RX FIFO empty flag
//   rxRdEn     RX FIFO read strobe (data returns one cycle later)
//   rxData     RX FIFO read data
//   memWrEn    memory byte write strobe
//   memAddr    memory byte address
//   memData    memory write data
//   cpuRstB    CPU reset, active-low
//   busy       high (one cycle late) while in SYNC/LEN/DATA/CSUM
//   done       one-cycle pulse on a verified load
//   err        sticky error: 00 none, 01 bad length, 10 checksum, 11 timeout
//   state      debug view of the sequencer state, encoded
//              BOOT=0 SYNC=1 LEN=2 DATA=3 CSUM=4 DONE=5 ERR=6 RUN=7
//
// FIFO handshake: a read is issued with rxRdEn only when the FIFO is not empty
// and no read is outstanding; rxData is taken exactly one cycle later (the
// "consume" cycle, rd_pend=1). At most one byte is therefore taken every two
// cycles and the FIFO is never read while empty.
module boot_loader_ctrl #(
  parameter int unsigned MEM_SIZE    = 32768,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rstB,
  input  logic        bootReq,
  input  logic        rxFfEmpty,
  output logic        rxRdEn,
  input  logic [7:0]  rxData,
  output logic        memWrEn,
  output logic [31:0] memAddr,
  output logic [7:0]  memData,
  output logic        cpuRstB,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_SYNC = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6,
    S_RUN  = 3'd7
  } state_t;

  state_t      st;
  logic [31:0] len;
  logic [31:0] cnt;
  logic [31:0] timer;
  logic [7:0]  sum;
  logic        rd_pend;
  logic        boot_req_q;

  logic        fetch_active;
  logic        consume;
  logic        timed_out;
  logic [31:0] len_shift;
  logic        len_bad;

  assign state = st;

  assign fetch_active = (st == S_SYNC) || (st == S_LEN) ||
                        (st == S_DATA) || (st == S_CSUM);
  // A read that was in flight when the state left the fetch states is dropped.
  assign consume      = rd_pend && fetch_active;
  assign rxRdEn       = fetch_active && !rxFfEmpty && !rd_pend;

  // A consumed byte on the terminal timer cycle takes priority over timeout.
  assign timed_out    = ((st == S_LEN) || (st == S_DATA) || (st == S_CSUM)) &&
                        (timer == 32'(TIMEOUT_CYC - 1)) && !consume;

  // Little-endian assembly: each new byte enters at the top and shifts down,
  // so after four bytes the first one sits in [7:0].
  assign len_shift    = {rxData, len[31:8]};
  assign len_bad      = (len_shift == 32'd0) || (len_shift > 32'(MEM_SIZE));

  // Memory port is gated so address/data read as zero outside a write; this
  // also keeps memAddr below MEM_SIZE after the final payload byte.
  assign memWrEn      = (st == S_DATA) && consume;
  assign memAddr      = memWrEn ? cnt : 32'd0;
  assign memData      = memWrEn ? rxData : 8'd0;

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      st         <= S_BOOT;
      cpuRstB    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 2'b00;
      len        <= 32'd0;
      cnt        <= 32'd0;
      sum        <= 8'd0;
      timer      <= 32'd0;
      rd_pend    <= 1'b0;
      boot_req_q <= 1'b0;
    end else begin
      rd_pend    <= rxRdEn;
      boot_req_q <= bootReq;
      busy       <= fetch_active;
      done       <= 1'b0;

      case (st)
        S_BOOT: begin
          if (bootReq) begin
            st <= S_SYNC;
          end else begin
            st      <= S_RUN;
            cpuRstB <= 1'b1;
          end
        end

        S_RUN: begin
          if (bootReq && !boot_req_q) begin
            st      <= S_SYNC;
            cpuRstB <= 1'b0;
          end
        end

        S_SYNC: begin
          if (consume && (rxData == SYNC_BYTE)) begin
            st    <= S_LEN;
            err   <= 2'b00;
            len   <= 32'd0;
            cnt   <= 32'd0;
            sum   <= 8'd0;
            timer <= 32'd0;
          end
        end

        // cnt counts length bytes here and is cleared again for the payload.
        S_LEN: begin
          if (consume) begin
            len   <= len_shift;
            timer <= 32'd0;
            if (cnt[1:0] == 2'd3) begin
              cnt <= 32'd0;
              if (len_bad) begin
                st  <= S_ERR;
                err <= 2'b01;
              end else begin
                st <= S_DATA;
              end
            end else begin
              cnt <= cnt + 32'd1;
            end
          end else if (timed_out) begin
            st  <= S_ERR;
            err <= 2'b11;
          end else begin
            timer <= timer + 32'd1;
          end
        end

        S_DATA: begin
          if (consume) begin
            cnt   <= cnt + 32'd1;
            sum   <= sum + rxData;
            timer <= 32'd0;
            if ((cnt + 32'd1) == len) st <= S_CSUM;
          end else if (timed_out) begin
            st  <= S_ERR;
            err <= 2'b11;
          end else begin
            timer <= timer + 32'd1;
          end
        end

        S_CSUM: begin
          if (consume) begin
            timer <= 32'd0;
            if (rxData == sum) begin
              st   <= S_DONE;
              done <= 1'b1;
            end else begin
              st  <= S_ERR;
              err <= 2'b10;
            end
          end else if (timed_out) begin
            st  <= S_ERR;
            err <= 2'b11;
          end else begin
            timer <= timer + 32'd1;
          end
        end

        S_DONE: begin
          st      <= S_RUN;
          cpuRstB <= 1'b1;
        end

        S_ERR: begin
          st <= S_SYNC;
        end

        default: begin
          st <= S_BOOT;
        end
      endcase
    end
  end

endmodule
